stk_pipe_wrbk: RTL and testbench
================================

Name: stk_pipe_wrbk

Overview:
Writeback stage of the stack pipeline; consumes the registered microcode and bank SRAM read data produced one cycle after the memory stage.
- Selects the addressed bank's data and previous-pointer words.
- Commits per-engine head/tail/occupancy state.
- Queues one response per microcode op toward the engine interface, with valid/ready flow control and upstream stall.

Parameters:
ENGS_N, 4, number of stack engines (per-engine state entries)
BANKS_N, 4, number of SRAM banks
PTR_W, 8, pointer width; stack capacity 2^PTR_W lines
DAT_W, 128, data word width
RSPQ_N, 2, response queue depth (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_wrbk_uc_vld  in  1  microcode valid
i_wrbk_uc_engid  in  log2(ENGS_N)  engine id
i_wrbk_uc_bankid  in  log2(BANKS_N)  bank read this op
i_wrbk_uc_op  in  2  stk_pkg::op_t: NOP=0, PUSH=1, POP=2
i_wrbk_uc_head_vld  in  1  head update present
i_wrbk_uc_head_ptr  in  PTR_W  new head (PUSH)
i_wrbk_uc_tail_vld  in  1  tail update present
i_wrbk_uc_tail_ptr  in  PTR_W  new tail
i_mem_prev_dout  in  BANKS_N*PTR_W  per-bank previous-pointer read data
i_mem_dat_dout  in  BANKS_N*DAT_W  per-bank data read data
o_wrbk_stall  out  1  response queue full; upstream holds ops
o_rsp_vld  out  1  response valid
i_rsp_rdy  in  1  response accepted
o_rsp_engid  out  log2(ENGS_N)  responding engine
o_rsp_op  out  2  op being acknowledged
o_rsp_err  out  1  overflow/underflow error
o_rsp_dat  out  DAT_W  popped data; 0 otherwise
o_st_head_vld  out  ENGS_N  per-engine head valid
o_st_head_ptr  out  ENGS_N*PTR_W  per-engine head pointer
o_st_tail_ptr  out  ENGS_N*PTR_W  per-engine tail pointer
o_st_empty  out  ENGS_N  per-engine occupancy==0

Behaviour:
Reset:
- All head_vld=0, head/tail ptrs=0, counts=0, o_st_empty=all 1.
- Queue empty: o_rsp_vld=0, o_rsp_*=0, o_wrbk_stall=0.

Op accept:
- An op is accepted when i_wrbk_uc_vld=1 and op!=NOP.
- Bank data is selected combinationally by i_wrbk_uc_bankid in the same cycle.

State commit:
- State commits at the clock edge ending the accept cycle and is visible on o_st_* the next cycle (1-cycle latency).

PUSH, count < 2^PTR_W:
- count++.
- If head_vld: head_ptr <- uc head_ptr, head_vld <- 1.
- If tail_vld: tail_ptr <- uc tail_ptr.
- err=0, dat=0.

PUSH, count == 2^PTR_W:
- No state change; err=1.

POP, count > 0:
- count--, dat <- selected data word.
- If count becomes 0: head_vld <- 0, head_ptr/tail_ptr unchanged.
- Otherwise: head_ptr <- selected prev pointer.
- err=0.

POP, count == 0:
- No state change; err=1, dat=0.

Counter width:
- Count width is PTR_W+1, with no wrap.

Response queue:
- Every accepted op enqueues exactly one response.
- o_rsp_vld rises the cycle after accept; 1-cycle minimum latency.
- Dequeue when o_rsp_vld && i_rsp_rdy; FIFO order is preserved.
- Enqueue and dequeue in the same cycle are both allowed; occupancy is unchanged.

Stall:
- o_wrbk_stall is registered, = (occupancy == RSPQ_N).
- An accept while stall=1 is a protocol violation: simulation assertion fires, the op is dropped, and state is unchanged.

Mid-operation reset and engine independence:
- rst mid-operation discards queued responses and all engine state in the same edge.
- Ops to different engines are independent; one op per cycle maximum.

Optional Feature:
STK_PIPE_WRBK_PERF_EN:
- When defined, adds outputs o_perf_push_cnt, o_perf_pop_cnt, o_perf_err_cnt (32 bits each).
- Counters are saturating, increment on the accepted op's commit edge, and are cleared by rst.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
stk_pkg:
- Types: op_t (NOP/PUSH/POP), engid_t, bank_id_t, ptr_t, cnt_t (PTR_W+1).
- Struct: rsp_t {engid, op, err, dat}.
- Constants: ENGS_N, BANKS_N, PTR_W.

Sub-module:
- stk_pipe_wrbk_rspq: parameterized valid/ready FIFO of rsp_t with registered full flag.

Test Plan:
1. Reset, then PUSH eng0 head=0x05 tail=0x05 -> next cycle o_st_head_ptr[0]=0x05, o_st_empty[0]=0; o_rsp_vld=1, op=PUSH, err=0.
2. Pushes eng1 heads 0x10,0x11; POP eng1 bank2 with prev_dout[2]=0x10, dat_dout[2]=0xDEAD -> rsp_dat=0xDEAD, head_ptr[1]=0x10, count 1.
3. POP eng2 when empty -> rsp_err=1, dat=0, eng2 state unchanged, o_st_empty[2]=1.
4. Hold i_rsp_rdy=0, issue 2 PUSHes -> o_wrbk_stall=1 after second; release rdy -> responses drain in order, stall clears the cycle after the first dequeue.
5. Fill eng3 to 256 pushes (PTR_W=8), push again -> err=1, count stays 256; pop -> err=0, count 255.
6. Assert rst with 2 responses queued -> next cycle o_rsp_vld=0, stall=0, all o_st_empty=1.

Source files
------------

// File: rtl/stk_pkg.sv
// Shared types and constants for the stack pipeline writeback stage.
package stk_pkg;

    localparam int ENGS_N  = 4;
    localparam int BANKS_N = 4;
    localparam int PTR_W   = 8;
    localparam int DAT_W   = 128;

    localparam int ENG_W  = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
    localparam int BANK_W = (BANKS_N > 1) ? $clog2(BANKS_N) : 1;
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2
    } op_t;

    typedef logic [ENG_W-1:0]  engid_t;
    typedef logic [BANK_W-1:0] bank_id_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [DAT_W-1:0]  dat_t;

    // Occupancy of a completely full stack (2^PTR_W lines).
    localparam cnt_t CNT_FULL = {1'b1, {PTR_W{1'b0}}};

    typedef struct packed {
        engid_t engid;
        op_t    op;
        logic   err;
        dat_t   dat;
    } rsp_t;

endpackage

// File: rtl/stk_pipe_wrbk_rspq.sv
// Small valid/ready FIFO of responses with a registered full flag.
module stk_pipe_wrbk_rspq
    import stk_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  rsp_t i_rsp,
    output logic o_full,
    output logic o_vld,
    input  logic i_rdy,
    output rsp_t o_rsp
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    rsp_t             mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    assign do_push = i_push && !o_full;
    assign do_pop  = o_vld && i_rdy;
    assign occ_nxt = occ + OCC_W'(do_push) - OCC_W'(do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            occ    <= '0;
            o_full <= 1'b0;
        end else begin
            if (do_push) wr_idx <= idx_inc(wr_idx);
            if (do_pop)  rd_idx <= idx_inc(rd_idx);
            occ    <= occ_nxt;
            o_full <= (occ_nxt == OCC_W'(DEPTH));
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= i_rsp;
    end

    assign o_vld = (occ != '0);
    assign o_rsp = o_vld ? mem[rd_idx] : '0;

endmodule

// File: rtl/stk_pipe_wrbk.sv
// Stack pipeline writeback: bank select, per-engine state commit, response queue.
// Optional STK_PIPE_WRBK_PERF_EN adds saturating push/pop/error counters.
module stk_pipe_wrbk
    import stk_pkg::*;
#(
    parameter int RSPQ_N = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wrbk_uc_vld,
    input  engid_t                     i_wrbk_uc_engid,
    input  bank_id_t                   i_wrbk_uc_bankid,
    input  op_t                        i_wrbk_uc_op,
    input  logic                       i_wrbk_uc_head_vld,
    input  ptr_t                       i_wrbk_uc_head_ptr,
    input  logic                       i_wrbk_uc_tail_vld,
    input  ptr_t                       i_wrbk_uc_tail_ptr,
    input  logic [BANKS_N*PTR_W-1:0]   i_mem_prev_dout,
    input  logic [BANKS_N*DAT_W-1:0]   i_mem_dat_dout,
    output logic                       o_wrbk_stall,
    output logic                       o_rsp_vld,
    input  logic                       i_rsp_rdy,
    output engid_t                     o_rsp_engid,
    output op_t                        o_rsp_op,
    output logic                       o_rsp_err,
    output dat_t                       o_rsp_dat,
    output logic [ENGS_N-1:0]          o_st_head_vld,
    output logic [ENGS_N*PTR_W-1:0]    o_st_head_ptr,
    output logic [ENGS_N*PTR_W-1:0]    o_st_tail_ptr,
    output logic [ENGS_N-1:0]          o_st_empty
`ifdef STK_PIPE_WRBK_PERF_EN
    ,
    output logic [31:0]                o_perf_push_cnt,
    output logic [31:0]                o_perf_pop_cnt,
    output logic [31:0]                o_perf_err_cnt
`endif
);

    // Handshake: a response transfers on a cycle where o_rsp_vld && i_rsp_rdy;
    // upstream must not present a non-NOP op while o_wrbk_stall is high.

    logic [ENGS_N-1:0] head_vld;
    ptr_t              head_ptr [ENGS_N];
    ptr_t              tail_ptr [ENGS_N];
    cnt_t              cnt      [ENGS_N];

    logic   accept;
    logic   do_push;
    logic   do_pop;
    cnt_t   cur_cnt;
    ptr_t   sel_prev;
    dat_t   sel_dat;
    rsp_t   rsp_in;
    rsp_t   rsp_out;

    assign accept   = i_wrbk_uc_vld && (i_wrbk_uc_op != OP_NOP) && !o_wrbk_stall;
    assign cur_cnt  = cnt[i_wrbk_uc_engid];
    assign sel_prev = i_mem_prev_dout[i_wrbk_uc_bankid*PTR_W +: PTR_W];
    assign sel_dat  = i_mem_dat_dout[i_wrbk_uc_bankid*DAT_W +: DAT_W];

    always_comb begin
        do_push       = 1'b0;
        do_pop        = 1'b0;
        rsp_in.engid  = i_wrbk_uc_engid;
        rsp_in.op     = i_wrbk_uc_op;
        rsp_in.err    = 1'b0;
        rsp_in.dat    = '0;
        if (accept) begin
            if (i_wrbk_uc_op == OP_PUSH) begin
                if (cur_cnt == CNT_FULL) rsp_in.err = 1'b1;
                else                     do_push    = 1'b1;
            end else if (i_wrbk_uc_op == OP_POP) begin
                if (cur_cnt == '0) begin
                    rsp_in.err = 1'b1;
                end else begin
                    do_pop     = 1'b1;
                    rsp_in.dat = sel_dat;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_vld <= '0;
            for (int e = 0; e < ENGS_N; e++) begin
                head_ptr[e] <= '0;
                tail_ptr[e] <= '0;
                cnt[e]      <= '0;
            end
        end else if (do_push) begin
            cnt[i_wrbk_uc_engid] <= cur_cnt + cnt_t'(1);
            if (i_wrbk_uc_head_vld) begin
                head_ptr[i_wrbk_uc_engid] <= i_wrbk_uc_head_ptr;
                head_vld[i_wrbk_uc_engid] <= 1'b1;
            end
            if (i_wrbk_uc_tail_vld) tail_ptr[i_wrbk_uc_engid] <= i_wrbk_uc_tail_ptr;
        end else if (do_pop) begin
            cnt[i_wrbk_uc_engid] <= cur_cnt - cnt_t'(1);
            // Last line leaving: pointers are kept, only validity drops.
            if (cur_cnt == cnt_t'(1)) head_vld[i_wrbk_uc_engid] <= 1'b0;
            else                      head_ptr[i_wrbk_uc_engid] <= sel_prev;
        end
    end

    stk_pipe_wrbk_rspq #(.DEPTH(RSPQ_N)) u_rspq (
        .clk    (clk),
        .rst    (rst),
        .i_push (accept),
        .i_rsp  (rsp_in),
        .o_full (o_wrbk_stall),
        .o_vld  (o_rsp_vld),
        .i_rdy  (i_rsp_rdy),
        .o_rsp  (rsp_out)
    );

    assign o_rsp_engid = rsp_out.engid;
    assign o_rsp_op    = rsp_out.op;
    assign o_rsp_err   = rsp_out.err;
    assign o_rsp_dat   = rsp_out.dat;

    always_comb begin
        o_st_head_ptr = '0;
        o_st_tail_ptr = '0;
        o_st_empty    = '0;
        for (int e = 0; e < ENGS_N; e++) begin
            o_st_head_ptr[e*PTR_W +: PTR_W] = head_ptr[e];
            o_st_tail_ptr[e*PTR_W +: PTR_W] = tail_ptr[e];
            o_st_empty[e]                   = (cnt[e] == '0);
        end
    end
    assign o_st_head_vld = head_vld;

`ifdef STK_PIPE_WRBK_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_perf_push_cnt <= '0;
            o_perf_pop_cnt  <= '0;
            o_perf_err_cnt  <= '0;
        end else if (accept) begin
            if (i_wrbk_uc_op == OP_PUSH && o_perf_push_cnt != '1)
                o_perf_push_cnt <= o_perf_push_cnt + 32'd1;
            if (i_wrbk_uc_op == OP_POP && o_perf_pop_cnt != '1)
                o_perf_pop_cnt <= o_perf_pop_cnt + 32'd1;
            if (rsp_in.err && o_perf_err_cnt != '1)
                o_perf_err_cnt <= o_perf_err_cnt + 32'd1;
        end
    end
`endif

    drop_on_stall_a: assert property (@(posedge clk) disable iff (rst)
        !(i_wrbk_uc_vld && (i_wrbk_uc_op != OP_NOP) && o_wrbk_stall));

endmodule

// File: tb/tb_stk_pipe_wrbk.sv
// Self-checking bench for stk_pipe_wrbk: reference model plus response scoreboard.
module tb_stk_pipe_wrbk;
    import stk_pkg::*;

    localparam int RSP_W = $bits(rsp_t);
    localparam int CHK_W = RSP_W;
    localparam int CAP   = 1 << PTR_W;

    logic                     clk;
    logic                     rst;
    logic                     i_wrbk_uc_vld;
    engid_t                   i_wrbk_uc_engid;
    bank_id_t                 i_wrbk_uc_bankid;
    op_t                      i_wrbk_uc_op;
    logic                     i_wrbk_uc_head_vld;
    ptr_t                     i_wrbk_uc_head_ptr;
    logic                     i_wrbk_uc_tail_vld;
    ptr_t                     i_wrbk_uc_tail_ptr;
    logic [BANKS_N*PTR_W-1:0] i_mem_prev_dout;
    logic [BANKS_N*DAT_W-1:0] i_mem_dat_dout;
    logic                     o_wrbk_stall;
    logic                     o_rsp_vld;
    logic                     i_rsp_rdy;
    engid_t                   o_rsp_engid;
    op_t                      o_rsp_op;
    logic                     o_rsp_err;
    dat_t                     o_rsp_dat;
    logic [ENGS_N-1:0]        o_st_head_vld;
    logic [ENGS_N*PTR_W-1:0]  o_st_head_ptr;
    logic [ENGS_N*PTR_W-1:0]  o_st_tail_ptr;
    logic [ENGS_N-1:0]        o_st_empty;
`ifdef STK_PIPE_WRBK_PERF_EN
    logic [31:0]              o_perf_push_cnt;
    logic [31:0]              o_perf_pop_cnt;
    logic [31:0]              o_perf_err_cnt;
`endif

    stk_pipe_wrbk #(.RSPQ_N(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_wrbk_uc_vld      (i_wrbk_uc_vld),
        .i_wrbk_uc_engid    (i_wrbk_uc_engid),
        .i_wrbk_uc_bankid   (i_wrbk_uc_bankid),
        .i_wrbk_uc_op       (i_wrbk_uc_op),
        .i_wrbk_uc_head_vld (i_wrbk_uc_head_vld),
        .i_wrbk_uc_head_ptr (i_wrbk_uc_head_ptr),
        .i_wrbk_uc_tail_vld (i_wrbk_uc_tail_vld),
        .i_wrbk_uc_tail_ptr (i_wrbk_uc_tail_ptr),
        .i_mem_prev_dout    (i_mem_prev_dout),
        .i_mem_dat_dout     (i_mem_dat_dout),
        .o_wrbk_stall       (o_wrbk_stall),
        .o_rsp_vld          (o_rsp_vld),
        .i_rsp_rdy          (i_rsp_rdy),
        .o_rsp_engid        (o_rsp_engid),
        .o_rsp_op           (o_rsp_op),
        .o_rsp_err          (o_rsp_err),
        .o_rsp_dat          (o_rsp_dat),
        .o_st_head_vld      (o_st_head_vld),
        .o_st_head_ptr      (o_st_head_ptr),
        .o_st_tail_ptr      (o_st_tail_ptr),
        .o_st_empty         (o_st_empty)
`ifdef STK_PIPE_WRBK_PERF_EN
        ,
        .o_perf_push_cnt    (o_perf_push_cnt),
        .o_perf_pop_cnt     (o_perf_pop_cnt),
        .o_perf_err_cnt     (o_perf_err_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and reference model
    logic [RSP_W-1:0] exp_q[$];
    int               n_checks;
    int               n_pass;
    int               m_cnt  [ENGS_N];
    logic             m_hvld [ENGS_N];
    ptr_t             m_head [ENGS_N];
    ptr_t             m_tail [ENGS_N];

    task automatic check(input string tag, input logic [CHK_W-1:0] act, input logic [CHK_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic model_reset();
        for (int e = 0; e < ENGS_N; e++) begin
            m_cnt[e]  = 0;
            m_hvld[e] = 1'b0;
            m_head[e] = '0;
            m_tail[e] = '0;
        end
    endtask

    // Called one time unit after a rising edge: scores a handshake that the
    // next edge completes, then advances one cycle.
    task automatic step();
        logic [RSP_W-1:0] e;
        if (o_rsp_vld && i_rsp_rdy && !rst) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", CHK_W'(1), CHK_W'(0));
            end else begin
                e = exp_q.pop_front();
                check("rsp", CHK_W'({o_rsp_engid, o_rsp_op, o_rsp_err, o_rsp_dat}), CHK_W'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input int eng);
        logic [ENGS_N-1:0] ev;
        logic [ENGS_N-1:0] ee;
        for (int e = 0; e < ENGS_N; e++) begin
            ev[e] = m_hvld[e];
            ee[e] = (m_cnt[e] == 0);
        end
        check("st_head_vld", CHK_W'(o_st_head_vld), CHK_W'(ev));
        check("st_empty", CHK_W'(o_st_empty), CHK_W'(ee));
        check("st_head_ptr", CHK_W'(o_st_head_ptr[eng*PTR_W +: PTR_W]), CHK_W'(m_head[eng]));
        check("st_tail_ptr", CHK_W'(o_st_tail_ptr[eng*PTR_W +: PTR_W]), CHK_W'(m_tail[eng]));
    endtask

    // driver: one op, model update, expected response pushed, state checked
    task automatic issue(input int eng, input int bank, input op_t op,
                         input logic hv, input ptr_t hp, input logic tv, input ptr_t tp,
                         input ptr_t prev, input dat_t dat);
        rsp_t r;
        for (int k = 0; k < 20 && o_wrbk_stall; k++) begin
            i_rsp_rdy = 1'b1;
            step();
        end
        if (o_wrbk_stall) begin
            check("stall_timeout", CHK_W'(1), CHK_W'(0));
            return;
        end
        for (int b = 0; b < BANKS_N; b++) begin
            i_mem_prev_dout[b*PTR_W +: PTR_W] = ptr_t'($urandom);
            i_mem_dat_dout[b*DAT_W +: DAT_W]  = {$urandom, $urandom, $urandom, $urandom};
        end
        i_mem_prev_dout[bank*PTR_W +: PTR_W] = prev;
        i_mem_dat_dout[bank*DAT_W +: DAT_W]  = dat;
        i_wrbk_uc_vld      = 1'b1;
        i_wrbk_uc_engid    = engid_t'(eng);
        i_wrbk_uc_bankid   = bank_id_t'(bank);
        i_wrbk_uc_op       = op;
        i_wrbk_uc_head_vld = hv;
        i_wrbk_uc_head_ptr = hp;
        i_wrbk_uc_tail_vld = tv;
        i_wrbk_uc_tail_ptr = tp;

        r.engid = engid_t'(eng);
        r.op    = op;
        r.err   = 1'b0;
        r.dat   = '0;
        if (op == OP_PUSH) begin
            if (m_cnt[eng] == CAP) r.err = 1'b1;
            else begin
                m_cnt[eng]++;
                if (hv) begin m_hvld[eng] = 1'b1; m_head[eng] = hp; end
                if (tv) m_tail[eng] = tp;
            end
        end else if (op == OP_POP) begin
            if (m_cnt[eng] == 0) r.err = 1'b1;
            else begin
                r.dat = dat;
                m_cnt[eng]--;
                if (m_cnt[eng] == 0) m_hvld[eng] = 1'b0;
                else                 m_head[eng] = prev;
            end
        end
        exp_q.push_back(RSP_W'(r));
        step();
        i_wrbk_uc_vld = 1'b0;
        i_wrbk_uc_op  = OP_NOP;
        check_state(eng);
    endtask

    task automatic drain();
        i_rsp_rdy = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        check("drain_left", CHK_W'(exp_q.size()), CHK_W'(0));
        check("drain_vld", CHK_W'(o_rsp_vld), CHK_W'(0));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        rst = 1'b1;
        i_wrbk_uc_vld = 1'b0;
        i_wrbk_uc_engid = '0;
        i_wrbk_uc_bankid = '0;
        i_wrbk_uc_op = OP_NOP;
        i_wrbk_uc_head_vld = 1'b0;
        i_wrbk_uc_head_ptr = '0;
        i_wrbk_uc_tail_vld = 1'b0;
        i_wrbk_uc_tail_ptr = '0;
        i_mem_prev_dout = '0;
        i_mem_dat_dout = '0;
        i_rsp_rdy = 1'b1;
        @(posedge clk); #1;
        step();
        check("rst_vld", CHK_W'(o_rsp_vld), CHK_W'(0));
        check("rst_stall", CHK_W'(o_wrbk_stall), CHK_W'(0));
        check("rst_rsp", CHK_W'({o_rsp_engid, o_rsp_op, o_rsp_err, o_rsp_dat}), CHK_W'(0));
        check("rst_empty", CHK_W'(o_st_empty), CHK_W'({ENGS_N{1'b1}}));
        check("rst_hvld", CHK_W'(o_st_head_vld), CHK_W'(0));
        check("rst_head", CHK_W'(o_st_head_ptr), CHK_W'(0));
        check("rst_tail", CHK_W'(o_st_tail_ptr), CHK_W'(0));
        rst = 1'b0;
        step();

        // 1: first push, response valid the cycle after accept
        issue(0, 0, OP_PUSH, 1'b1, 8'h05, 1'b1, 8'h05, '0, '0);
        check("t1_rsp_vld", CHK_W'(o_rsp_vld), CHK_W'(1));
        drain();

        // 2: pushes then pop selecting bank 2
        issue(1, 0, OP_PUSH, 1'b1, 8'h10, 1'b1, 8'h10, '0, '0);
        issue(1, 1, OP_PUSH, 1'b1, 8'h11, 1'b0, '0, '0, '0);
        issue(1, 2, OP_POP, 1'b0, '0, 1'b0, '0, 8'h10, dat_t'(128'hDEAD));
        drain();

        // 3: underflow on an empty engine
        issue(2, 3, OP_POP, 1'b0, '0, 1'b0, '0, 8'h77, dat_t'(128'hBEEF));
        drain();

        // 4: backpressure fills the queue, stall clears after first dequeue
        i_rsp_rdy = 1'b0;
        issue(0, 1, OP_PUSH, 1'b1, 8'h06, 1'b0, '0, '0, '0);
        check("t4_stall_one", CHK_W'(o_wrbk_stall), CHK_W'(0));
        issue(0, 1, OP_PUSH, 1'b1, 8'h07, 1'b0, '0, '0, '0);
        check("t4_stall_full", CHK_W'(o_wrbk_stall), CHK_W'(1));
        i_rsp_rdy = 1'b1;
        step();
        check("t4_stall_clr", CHK_W'(o_wrbk_stall), CHK_W'(0));
        drain();

        // 5: fill eng3 to capacity, overflow, then pop
        for (int i = 0; i < CAP; i++)
            issue(3, i % BANKS_N, OP_PUSH, 1'b1, ptr_t'(i), (i == 0), ptr_t'(i), '0, '0);
        issue(3, 0, OP_PUSH, 1'b1, 8'hAA, 1'b1, 8'hAA, '0, '0);
        issue(3, 1, OP_POP, 1'b0, '0, 1'b0, '0, 8'hFE, dat_t'(128'h1234_5678));
        drain();

        // random mix across engines 0..2 with random backpressure
        for (int i = 0; i < 60; i++) begin
            i_rsp_rdy = 1'($urandom_range(0, 1));
            issue($urandom_range(0, 2), $urandom_range(0, BANKS_N - 1),
                  ($urandom_range(0, 1) == 1) ? OP_POP : OP_PUSH,
                  1'($urandom_range(0, 1)), ptr_t'($urandom), 1'($urandom_range(0, 1)),
                  ptr_t'($urandom), ptr_t'($urandom), {$urandom, $urandom, $urandom, $urandom});
        end
        drain();

        // 6: reset with two responses queued
        i_rsp_rdy = 1'b0;
        issue(0, 0, OP_PUSH, 1'b1, 8'h20, 1'b0, '0, '0, '0);
        issue(1, 0, OP_PUSH, 1'b1, 8'h21, 1'b0, '0, '0, '0);
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        step();
        rst = 1'b0;
        check("t6_vld", CHK_W'(o_rsp_vld), CHK_W'(0));
        check("t6_stall", CHK_W'(o_wrbk_stall), CHK_W'(0));
        check("t6_empty", CHK_W'(o_st_empty), CHK_W'({ENGS_N{1'b1}}));
        check("t6_hvld", CHK_W'(o_st_head_vld), CHK_W'(0));
        i_rsp_rdy = 1'b1;
        issue(2, 0, OP_PUSH, 1'b1, 8'h33, 1'b1, 8'h33, '0, '0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
